// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: reset vector, fetch state encoding, NOP word
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_OUT  = 2'd2
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch unit bundle: instruction memory, redirect and decode handshake
interface inst_fetch_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_adel;

    modport master (
        output inst_req, inst_addr, id_valid, id_inst, id_pc, id_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  inst_req, inst_addr, id_valid, id_inst, id_pc, id_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - fetch program counter with reset vector, +4 step and redirect override
module pc_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Redirect beats the sequential step when both land in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch stage feeding decode
module inst_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    fetch_state_e state_q;
    logic         discard_q;
    logic         id_valid_q;
    logic [31:0]  id_inst_q;
    logic [31:0]  id_pc_q;
    logic         id_adel_q;
    logic [31:0]  pc;
    logic         pc_bad;
    logic         out_accept;

    assign pc_bad     = pc_misaligned(pc[1:0]);
    assign out_accept = (state_q == FS_OUT) && bus.id_ready;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .inc_i         (out_accept),
        .redirect_i    (bus.redirect),
        .redirect_pc_i (bus.redirect_pc),
        .pc_o          (pc)
    );

    // A redirect cancels the request in its own cycle so a stale address never reaches memory.
    assign bus.inst_req  = !rst && (state_q == FS_REQ) && !bus.redirect && !pc_bad;
    assign bus.inst_addr = pc;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_adel   = id_adel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_REQ;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= INST_NOP;
            id_pc_q    <= 32'h0;
            id_adel_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (bus.redirect) begin
                        state_q <= FS_REQ;
                    end else if (pc_bad) begin
                        state_q    <= FS_OUT;
                        id_valid_q <= 1'b1;
                        id_inst_q  <= INST_NOP;
                        id_pc_q    <= pc;
                        id_adel_q  <= 1'b1;
                    end else if (bus.inst_addr_ok) begin
                        state_q <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    // The outstanding response must still be drained after a redirect.
                    if (bus.inst_data_ok) begin
                        if (bus.redirect || discard_q) begin
                            state_q   <= FS_REQ;
                            discard_q <= 1'b0;
                        end else begin
                            state_q    <= FS_OUT;
                            id_valid_q <= 1'b1;
                            id_inst_q  <= bus.inst_rdata;
                            id_pc_q    <= pc;
                            id_adel_q  <= 1'b0;
                        end
                    end else if (bus.redirect) begin
                        discard_q <= 1'b1;
                    end
                end
                FS_OUT: begin
                    if (bus.redirect || bus.id_ready) begin
                        state_q    <= FS_REQ;
                        id_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= FS_REQ;
                    id_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
